led_bank_arbiter: RTL and testbench
===================================

Name: led_bank_arbiter

Overview:
- Shares the 8-bit LED bank between NREQ requesters (firmware status, debug sources, tProc flags) using a round-robin scheme with a minimum dwell time per owner.
- When nobody owns the bank, it shows an internal idle pattern: an 8-bit Galois LFSR advanced by a programmable prescaler.
- Sits between the pattern sources and the board LED pins, and replaces any free-running blinker.

Parameters:
NREQ, 4, number of requesters (2..8)
DWELL_W, 16, width of dwell_cycles and the dwell counter
DIV_W, 8, width of idle_div and the idle prescaler

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
req  in  NREQ  per-requester ownership request, level-sensitive
req_data  in  8*NREQ  LED value of requester i, carried on bits [8i+7:8i]
dwell_cycles  in  DWELL_W  minimum ownership before preemption; sampled at grant
idle_div  in  DIV_W  idle LFSR advances once every idle_div+1 cycles
grant  out  NREQ  one-hot current owner; all zero when idle
busy  out  1  high while some requester owns the bank
led_output  out  8  registered LED drive

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-ownership):
  - state=IDLE, grant=0, busy=0, led_output=8'h00.
  - lfsr=8'hFF, prescaler=0, rr_ptr=0, dwell_cnt=0.
- Every output is registered. No combinational path runs from inputs to outputs.
- LFSR next-state: next={l[6], l[5]^l[7], l[4]^l[7], l[3]^l[7], l[2], l[1], l[0], l[7]}.
  - If lfsr==0 (lock-up), load 8'hFF instead.
- Arbitration function: pick the first index with req set, scanning from rr_ptr upward and wrapping modulo NREQ. When granting index i, set rr_ptr=(i+1) mod NREQ.
- State IDLE:
  - prescaler counts 0..idle_div. When prescaler==idle_div, it wraps to 0 and lfsr advances.
  - led_output<=lfsr (the value before the advance, so output trails lfsr by 1 cycle).
  - If |req: next edge sets state=OWN, grant=onehot(winner), busy=1, dwell_cnt=dwell_cycles, led_output<=req_data[winner].
  - The lfsr does not advance on the transition edge.
- State OWN (owner o):
  - led_output<=req_data[o] every cycle (1-cycle latency).
  - dwell_cnt decrements by 1 per cycle and saturates at 0.
  - lfsr and prescaler are frozen.
- Transitions out of OWN, evaluated every cycle in this priority:
  1. req[o]==0 and other requests are pending: hand over directly to the arbitration winner at the next edge, with no idle gap. Reload dwell_cnt.
  2. req[o]==0 and no other request: go to IDLE at the next edge. grant=0, busy=0, prescaler=0. The LFSR resumes from its frozen value. From that edge led_output shows the frozen lfsr.
  3. req[o]==1, dwell_cnt==0 and another requester is pending: preempt to the arbitration winner (it cannot be o, because rr_ptr already points past o).
  4. Otherwise o keeps the grant.
- Under continuous contention each owner holds the grant for exactly dwell_cycles+1 cycles.
- dwell_cycles==0 means the owner may be preempted after a single cycle.
- Changes to dwell_cycles have no effect on the current ownership; the new value applies at the next grant.
- Changes to idle_div take effect on the next prescaler comparison. If the prescaler is already above the new idle_div, it counts up, wraps at the maximum width and then matches (this behaviour is documented and not an error).
- A requester that drops and reasserts req while not the owner simply re-enters arbitration. There are no stored requests.
- grant is always one-hot or zero. busy==|grant at all times.

Test Plan:
- Reset and idle pattern:
  - Hold aresetn low → grant=0, busy=0, led_output=00.
  - Release with req=0 and idle_div=0 → led_output sequence 00, FF, 8F, 6F, ... (one step per cycle).
- Idle prescaler: idle_div=2, req=0 → led_output changes every 3 cycles (FF ×3, 8F ×3, 6F ×3).
- Single owner passthrough:
  - req=4'b0100, req_data[2]=8'hA5 → grant=0100, busy=1 one edge later, led_output=A5 one edge after that.
  - Change req_data[2] to 3C → led_output=3C 1 cycle later.
- Round-robin with dwell: req=4'b1111, dwell_cycles=3 → grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles with no zero-grant gaps.
- Release and resume:
  - Owner 1 drops req with no others pending → next edge grant=0, busy=0.
  - led_output returns to the LFSR value frozen at grant time, then continues the idle sequence.
- Async reset mid-ownership: assert aresetn low between clock edges while grant=0010 → grant, busy and led_output clear immediately without waiting for a clock edge. After release, the idle sequence restarts from FF.

Source files
------------

// File: rtl/led_bank_if.sv
// LED bank bus: requester side (req/req_data) and the arbitrated result.
interface led_bank_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [7:0]        led_output;

    modport master (output req, req_data, input grant, busy, led_output);
    modport slave  (input req, req_data, output grant, busy, led_output);
endinterface

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the 8-bit LED bank with a minimum dwell per owner.
// With no owner the bank shows an 8-bit Galois LFSR stepped by a prescaler.
module led_bank_arbiter #(
    parameter int NREQ    = 4,
    parameter int DWELL_W = 16,
    parameter int DIV_W   = 8
) (
    input  logic               aclk,
    input  logic               aresetn,
    led_bank_if.slave          bus,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic [DIV_W-1:0]   idle_div
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR = NREQ;

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t             state;
    logic [NREQ-1:0]    grant_q;
    logic               busy_q;
    logic [7:0]         led_q;
    logic [7:0]         lfsr;
    logic [DIV_W-1:0]   prescaler;
    logic [PW-1:0]      rr_ptr;
    logic [DWELL_W-1:0] dwell_cnt;

    logic [PW-1:0]      win;
    logic [PW-1:0]      rr_next;
    logic [NREQ-1:0]    win_onehot;
    logic [7:0]         data_win;
    logic [7:0]         data_own;
    logic [7:0]         lfsr_next;
    logic               own_req;
    logic               others;

    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.led_output = led_q;

    // Round-robin winner: first requester at or after rr_ptr, wrapping
    always_comb begin
        logic        found;
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NR) idx = idx - NR;
            if (!found && bus.req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Data lanes of the winner and of the current owner
    always_comb begin
        data_win = '0;
        data_own = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (win == PW'(i)) data_win = bus.req_data[8*i +: 8];
            if (grant_q[i])    data_own = bus.req_data[8*i +: 8];
        end
    end

    // Derived arbitration terms and next LFSR value (lock-up reloads all ones)
    always_comb begin
        rr_next    = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
        win_onehot = NREQ'(1'b1) << win;
        own_req    = |(bus.req & grant_q);
        others     = |(bus.req & ~grant_q);
        if (lfsr == 8'h00)
            lfsr_next = 8'hFF;
        else
            lfsr_next = {lfsr[6], lfsr[5]^lfsr[7], lfsr[4]^lfsr[7], lfsr[3]^lfsr[7],
                         lfsr[2], lfsr[1], lfsr[0], lfsr[7]};
    end

    // Ownership FSM with registered grant/busy/led outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            led_q     <= 8'h00;
            lfsr      <= 8'hFF;
            prescaler <= '0;
            rr_ptr    <= '0;
            dwell_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state     <= ST_OWN;
                        grant_q   <= win_onehot;
                        busy_q    <= 1'b1;
                        dwell_cnt <= dwell_cycles;
                        led_q     <= data_win;
                        rr_ptr    <= rr_next;
                    end else begin
                        led_q <= lfsr;
                        if (prescaler == idle_div) begin
                            prescaler <= '0;
                            lfsr      <= lfsr_next;
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                end
                ST_OWN: begin
                    if (!own_req && !others) begin
                        state     <= ST_IDLE;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        prescaler <= '0;
                        led_q     <= lfsr;
                    end else if (others && (!own_req || dwell_cnt == '0)) begin
                        // Handover and preemption share one path: the scan
                        // starts past the owner, so the winner is never it.
                        grant_q   <= win_onehot;
                        dwell_cnt <= dwell_cycles;
                        led_q     <= data_win;
                        rr_ptr    <= rr_next;
                    end else begin
                        led_q <= data_own;
                        if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed and randomized checks of led_bank_arbiter against a cycle model.
module tb_led_bank_arbiter;
    localparam int NREQ = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] dwell_cycles = '0;
    logic [7:0]  idle_div = '0;

    int total = 0;
    int bad   = 0;

    led_bank_if #(.NREQ(NREQ)) bus ();

    led_bank_arbiter #(.NREQ(NREQ), .DWELL_W(16), .DIV_W(8)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus),
        .dwell_cycles(dwell_cycles),
        .idle_div(idle_div)
    );

    always #5 aclk = ~aclk;

    // Reference model state: owner index (-1 = idle), plain integers
    int         m_owner, m_pre, m_rr, m_dw;
    logic [7:0] m_lfsr, m_led;

    function automatic logic [7:0] adv(input logic [7:0] l);
        logic [7:0] r;
        if (l == 8'h00) return 8'hFF;
        r = {l[6:0], l[7]};
        if (l[7]) r = r ^ 8'h70;
        return r;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_owner = -1; m_pre = 0; m_rr = 0; m_dw = 0;
        m_lfsr = 8'hFF; m_led = 8'h00;
    endtask

    task automatic m_grant(input int w, input logic [7:0] d);
        m_owner = w;
        m_rr    = (w + 1) % NREQ;
        m_dw    = int'(dwell_cycles);
        m_led   = d;
    endtask

    task automatic m_step();
        logic [7:0] dat [NREQ];
        int w;
        bit mine, others;
        for (int i = 0; i < NREQ; i++) dat[i] = bus.req_data[8*i +: 8];
        w = pick(bus.req, m_rr);
        if (m_owner < 0) begin
            if (bus.req != '0) begin
                m_grant(w, dat[w]);
            end else begin
                m_led = m_lfsr;
                if (m_pre == int'(idle_div)) begin
                    m_pre  = 0;
                    m_lfsr = adv(m_lfsr);
                end else begin
                    m_pre = (m_pre + 1) % 256;
                end
            end
        end else begin
            mine   = bus.req[m_owner];
            others = (bus.req & ~(NREQ'(1) << m_owner)) != '0;
            if (!mine && !others) begin
                m_owner = -1;
                m_pre   = 0;
                m_led   = m_lfsr;
            end else if (others && (!mine || m_dw == 0)) begin
                m_grant(w, dat[w]);
            end else begin
                m_led = dat[m_owner];
                if (m_dw > 0) m_dw--;
            end
        end
    endtask

    function automatic logic [NREQ-1:0] m_grant_vec();
        return (m_owner < 0) ? '0 : NREQ'(1) << m_owner;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model consumes current inputs, DUT sampled 1 ns after the edge
    task automatic tick(input int n = 1);
        repeat (n) begin
            m_step();
            @(posedge aclk);
            #1;
            chk("model_grant", 32'(bus.grant), 32'(m_grant_vec()));
            chk("model_busy", 32'(bus.busy), 32'(m_owner >= 0));
            chk("model_led", 32'(bus.led_output), 32'(m_led));
        end
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        bus.req_data[8*i +: 8] = v;
    endtask

    // Pulse reset between edges; called just after a posedge
    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        m_reset();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_led", 32'(bus.led_output), 32'h0);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_seq [9];
        logic [7:0] frozen;

        bus.req      = '0;
        bus.req_data = '0;
        m_reset();
        #2;
        chk("rst_hold_grant", 32'(bus.grant), 32'h0);
        chk("rst_hold_busy", 32'(bus.busy), 32'h0);
        chk("rst_hold_led", 32'(bus.led_output), 32'h0);
        @(posedge aclk);
        #1;
        do_reset();

        // Idle pattern, one LFSR step per cycle
        idle_div = 8'd0;
        exp_seq[0] = 8'hFF; exp_seq[1] = 8'h8F; exp_seq[2] = 8'h6F;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_seq", 32'(bus.led_output), 32'(exp_seq[i]));
        end

        // Prescaled idle pattern, each value held three cycles
        do_reset();
        idle_div = 8'd2;
        for (int i = 0; i < 9; i++) exp_seq[i] = (i < 3) ? 8'hFF : (i < 6) ? 8'h8F : 8'h6F;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("idle_div2", 32'(bus.led_output), 32'(exp_seq[i]));
        end

        // Single owner passthrough
        dwell_cycles = 16'd3;
        set_data(2, 8'hA5);
        bus.req = 4'b0100;
        tick();
        chk("single_grant", 32'(bus.grant), 32'h4);
        chk("single_busy", 32'(bus.busy), 32'h1);
        tick();
        chk("single_led", 32'(bus.led_output), 32'hA5);
        set_data(2, 8'h3C);
        tick();
        chk("single_led_chg", 32'(bus.led_output), 32'h3C);

        // Round robin under full contention, dwell 3 -> 4 cycles each
        bus.req = '0;
        tick();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, 8'(8'h10 * (i + 1)));
        dwell_cycles = 16'd3;
        bus.req = 4'b1111;
        for (int n = 0; n < 20; n++) begin
            tick();
            chk("rr_grant", 32'(bus.grant), 32'(4'b0001 << ((n / 4) % 4)));
        end

        // Release and resume from the frozen LFSR value
        bus.req = '0;
        tick();
        do_reset();
        idle_div = 8'd0;
        tick(3);
        frozen = adv(adv(adv(8'hFF)));
        set_data(1, 8'h5A);
        bus.req = 4'b0010;
        tick();
        chk("rel_grant", 32'(bus.grant), 32'h2);
        tick(3);
        chk("rel_led", 32'(bus.led_output), 32'h5A);
        bus.req = '0;
        tick();
        chk("rel_idle_grant", 32'(bus.grant), 32'h0);
        chk("rel_idle_busy", 32'(bus.busy), 32'h0);
        chk("rel_frozen", 32'(bus.led_output), 32'(frozen));
        tick();
        chk("rel_frozen2", 32'(bus.led_output), 32'(frozen));
        tick();
        chk("rel_resume", 32'(bus.led_output), 32'(adv(frozen)));

        // Asynchronous reset in the middle of an ownership
        bus.req = 4'b0010;
        tick(2);
        chk("ar_pre_grant", 32'(bus.grant), 32'h2);
        #2;
        aresetn = 1'b0;
        #1;
        chk("ar_grant", 32'(bus.grant), 32'h0);
        chk("ar_busy", 32'(bus.busy), 32'h0);
        chk("ar_led", 32'(bus.led_output), 32'h0);
        m_reset();
        #3;
        bus.req = '0;
        aresetn = 1'b1;
        tick();
        chk("ar_restart", 32'(bus.led_output), 32'hFF);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) bus.req = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) set_data($urandom_range(0, NREQ-1), 8'($urandom));
            if ($urandom_range(0, 19) == 0) dwell_cycles = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) idle_div = 8'($urandom_range(0, 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
